// File: rtl/irq_arbiter_if.sv
// CPU-side register bus of the interrupt arbiter (clk_2 domain).
// Member names follow the slave's view of the bus.
interface irq_arbiter_if;
    logic       i_cs;
    logic       i_rwb;
    logic [2:0] i_addr;
    logic [7:0] i_data;
    logic [7:0] o_data;

    modport master (output i_cs, i_rwb, i_addr, i_data, input  o_data);
    modport slave  (input  i_cs, i_rwb, i_addr, i_data, output o_data);
endinterface

// File: rtl/irq_arbiter.sv
// Eight-source interrupt arbiter sharing the 65C02 IRQB line: synchronizes and
// latches requests, masks them, and hands out source IDs through a CLAIM register.
module irq_arbiter (
    input  logic          i_clk,
    input  logic          i_rst_n,
    irq_arbiter_if.slave  bus,
    input  logic [7:0]    i_irqb,
    output logic          o_irqb
);
    typedef enum logic [2:0] {
        REG_PENDING = 3'd0,
        REG_ENABLE  = 3'd1,
        REG_EDGE    = 3'd2,
        REG_CTRL    = 3'd3,
        REG_CLAIM   = 3'd4,
        REG_RAW     = 3'd5
    } reg_addr_e;

    logic [7:0] sync1, irq_s, irq_d;
    logic [7:0] pend, enable, edge_mode;
    logic       gie, rr;
    logic [2:0] rr_ptr;

    logic [7:0] pend_eff, active, w1c, claim_clr, pend_next;
    logic       wr_en, claim_rd, win_valid;
    logic [2:0] win_id;

    assign pend_eff = (pend & edge_mode) | (irq_s & ~edge_mode);
    assign active   = pend_eff & enable;
    assign wr_en    = bus.i_cs & ~bus.i_rwb;
    assign claim_rd = bus.i_cs & bus.i_rwb & (bus.i_addr == REG_CLAIM);

    // Search starts at 0 in fixed mode or rr_ptr in round-robin mode; scanning
    // offsets downward lets the smallest offset overwrite the result last.
    always_comb begin
        logic [2:0] base;
        logic [2:0] idx;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_valid = 1'b0;
        win_id    = 3'd0;
        idx       = 3'd0;
        base      = rr ? rr_ptr : 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (active[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        w1c       = (wr_en && (bus.i_addr == REG_PENDING)) ? bus.i_data : 8'h00;
        claim_clr = 8'h00;
        if (claim_rd && win_valid) claim_clr[win_id] = 1'b1;
        // A new edge beats a same-cycle clear; level-mode bits hold the flop at 0.
        pend_next = edge_mode & ((irq_s & ~irq_d) | (pend & ~(w1c | claim_clr)));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1     <= 8'h00;
            irq_s     <= 8'h00;
            irq_d     <= 8'h00;
            pend      <= 8'h00;
            enable    <= 8'h00;
            edge_mode <= 8'h00;
            gie       <= 1'b0;
            rr        <= 1'b0;
            rr_ptr    <= 3'd0;
            o_irqb    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, which the sync chain relies on.
            sync1  <= ~i_irqb;
            irq_s  <= sync1;
            irq_d  <= irq_s;
            pend   <= pend_next;
            o_irqb <= ~(gie & (|active));
            if (claim_rd && win_valid) rr_ptr <= win_id + 3'd1;
            if (wr_en) begin
                case (bus.i_addr)
                    REG_ENABLE: enable     <= bus.i_data;
                    REG_EDGE:   edge_mode  <= bus.i_data;
                    REG_CTRL:   {rr, gie}  <= bus.i_data[1:0];
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        bus.o_data = 8'h00;
        case (bus.i_addr)
            REG_PENDING: bus.o_data = pend_eff;
            REG_ENABLE:  bus.o_data = enable;
            REG_EDGE:    bus.o_data = edge_mode;
            REG_CTRL:    bus.o_data = {6'b0, rr, gie};
            REG_CLAIM:   bus.o_data = win_valid ? {1'b1, 4'b0, win_id} : 8'h00;
            REG_RAW:     bus.o_data = irq_s;
            default:     bus.o_data = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: a directed vector table for the documented scenarios,
// then random traffic checked against a cycle-level reference model.
module tb_irq_arbiter;
    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_irqb  = 8'hFF;
    logic       o_irqb;
    int         n_tests = 0;
    int         n_fail  = 0;

    irq_arbiter_if bus ();
    irq_arbiter dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus), .i_irqb(i_irqb), .o_irqb(o_irqb));

    always #5 i_clk = ~i_clk;

    // Reference model: request samples kept newest-first ([1] is the synchronized
    // level, [2] the one before it), pending bits, registers and the RR pointer.
    logic [7:0] m_samp [$];
    logic [7:0] m_pend, m_en, m_edge;
    logic       m_gie, m_rr, m_irqb;
    int         m_ptr;

    task automatic model_reset();
        m_samp = '{8'h00, 8'h00, 8'h00};
        m_pend = 8'h00; m_en = 8'h00; m_edge = 8'h00;
        m_gie = 1'b0; m_rr = 1'b0; m_ptr = 0; m_irqb = 1'b1;
    endtask

    function automatic logic [7:0] m_active();
        return ((m_pend & m_edge) | (m_samp[1] & ~m_edge)) & m_en;
    endfunction

    function automatic int m_winner();   // -1 when nothing is active
        logic [7:0] act = m_active();
        int base = m_rr ? m_ptr : 0;
        for (int k = 0; k < 8; k++)
            if (act[(base + k) % 8]) return (base + k) % 8;
        return -1;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        int w = m_winner();
        case (a)
            3'd0: return (m_pend & m_edge) | (m_samp[1] & ~m_edge);
            3'd1: return m_en;
            3'd2: return m_edge;
            3'd3: return {6'b0, m_rr, m_gie};
            3'd4: return (w < 0) ? 8'h00 : 8'(8'h80 + w);
            3'd5: return m_samp[1];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input logic cs, input logic rwb, input logic [2:0] a,
                              input logic [7:0] d, input logic [7:0] irqb);
        logic [7:0] act = m_active();
        logic [7:0] s = m_samp[1];
        logic [7:0] dl = m_samp[2];
        logic [7:0] p;
        int  w = m_winner();
        bit  claim = cs && rwb && (a == 3'd4) && (w >= 0);
        bit  wr = cs && !rwb;
        for (int i = 0; i < 8; i++) begin
            if (!m_edge[i])                          p[i] = 1'b0;
            else if (s[i] && !dl[i])                 p[i] = 1'b1;
            else if ((wr && a == 3'd0 && d[i]) || (claim && w == i)) p[i] = 1'b0;
            else                                     p[i] = m_pend[i];
        end
        m_irqb = !(m_gie && (act != 8'h00));
        if (wr && a == 3'd1) m_en = d;
        if (wr && a == 3'd2) m_edge = d;
        if (wr && a == 3'd3) {m_rr, m_gie} = d[1:0];
        if (claim) m_ptr = (w + 1) % 8;
        m_pend = p;
        m_samp.push_front(~irqb);
        void'(m_samp.pop_back());
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
        end
    endtask

    // One bus cycle, entered and left at a falling edge; outputs sampled 1 time unit after driving.
    task automatic cycle(input logic rst, input logic cs, input logic rwb, input logic [2:0] a,
                         input logic [7:0] d, input logic [7:0] irqb,
                         output logic [7:0] got_d, output logic got_i,
                         output logic [7:0] exp_d, output logic exp_i);
        i_rst_n = ~rst; bus.i_cs = cs; bus.i_rwb = rwb; bus.i_addr = a; bus.i_data = d; i_irqb = irqb;
        if (rst) model_reset();
        #1;
        got_d = bus.o_data; got_i = o_irqb;
        exp_d = m_read(a);  exp_i = m_irqb;
        @(posedge i_clk);
        if (!rst) model_edge(cs, rwb, a, d, irqb);
        @(negedge i_clk);
    endtask

    typedef struct {
        logic       rst, cs, rwb;
        logic [2:0] addr;
        logic [7:0] data, irqb;
        int         exp_data;   // -1: not checked
        int         exp_irq;    // -1: not checked
    } vec_t;
    vec_t  vecs [$];
    string vnames [$];

    task automatic add(input logic rst, input logic cs, input logic rwb, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] irqb, input int ed, input int ei,
                       input string nm);
        vec_t v;
        v.rst = rst; v.cs = cs; v.rwb = rwb; v.addr = a; v.data = d; v.irqb = irqb;
        v.exp_data = ed; v.exp_irq = ei;
        vecs.push_back(v); vnames.push_back(nm);
    endtask
    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] q);
        add(1'b0, 1'b1, 1'b0, a, d, q, -1, -1, "wr");
    endtask
    task automatic rd(input logic [2:0] a, input int ed, input logic [7:0] q, input int ei, input string nm);
        add(1'b0, 1'b1, 1'b1, a, 8'h00, q, ed, ei, nm);
    endtask
    task automatic pk(input logic [2:0] a, input int ed, input logic [7:0] q, input int ei, input string nm);
        add(1'b0, 1'b0, 1'b1, a, 8'h00, q, ed, ei, nm);
    endtask
    task automatic idl(input logic [7:0] q, input int ei, input string nm);
        add(1'b0, 1'b0, 1'b1, 3'd7, 8'h00, q, -1, ei, nm);
    endtask
    task automatic rs(input logic [7:0] q, input string nm);
        add(1'b1, 1'b0, 1'b1, 3'd7, 8'h00, q, -1, 1, nm);
    endtask

    initial begin
        logic [7:0] gd, ed, q;
        logic       gi, ei;
        bus.i_cs = 1'b0; bus.i_rwb = 1'b1; bus.i_addr = 3'd0; bus.i_data = 8'h00;
        model_reset();
        repeat (3) @(negedge i_clk);

        // Reset and idle
        idl(8'hFF, 1, "idle");
        for (int a = 0; a < 6; a++) pk(3'(a), 0, 8'hFF, 1, $sformatf("idle_rd%0d", a));
        rd(3'd4, 0, 8'hFF, 1, "idle_claim");
        // Level masking: low after the third sampling edge, high within 3 edges of release
        wr(3'd1, 8'h04, 8'hFF); wr(3'd3, 8'h01, 8'hFF);
        idl(8'hFB, 1, "lvl_e0"); idl(8'hFB, 1, "lvl_e1"); idl(8'hFB, 1, "lvl_e2");
        pk(3'd0, 8'h04, 8'hFB, 0, "lvl_low");
        rd(3'd4, 8'h82, 8'hFB, 0, "lvl_claim");
        rd(3'd0, 8'h04, 8'hFB, 0, "lvl_pend");
        idl(8'hFF, 0, "lvl_r0"); idl(8'hFF, 0, "lvl_r1"); idl(8'hFF, 0, "lvl_r2");
        idl(8'hFF, 1, "lvl_release");
        // Edge latch and W1C
        wr(3'd2, 8'h01, 8'hFF); wr(3'd1, 8'h01, 8'hFF);
        idl(8'hFE, 1, "edg_e0"); idl(8'hFE, 1, "edg_e1");
        idl(8'hFF, 1, "edg_e2"); idl(8'hFF, 1, "edg_e3");
        idl(8'hFF, 0, "edg_low");
        pk(3'd0, 8'h01, 8'hFF, 0, "edg_pend");
        idl(8'hFF, 0, "edg_hold0"); idl(8'hFF, 0, "edg_hold1");
        wr(3'd0, 8'h01, 8'hFF);
        pk(3'd0, 8'h00, 8'hFF, 0, "w1c_pend");
        idl(8'hFF, 1, "w1c_irqb");
        // Fixed priority: sources 5 and 3
        wr(3'd2, 8'hFF, 8'hFF); wr(3'd1, 8'hFF, 8'hFF);
        idl(8'hD7, 1, "fix_e0"); idl(8'hD7, 1, "fix_e1"); idl(8'hD7, 1, "fix_e2");
        idl(8'hFF, 1, "fix_e3"); idl(8'hFF, 0, "fix_low");
        rd(3'd4, 8'h83, 8'hFF, 0, "fix_claim0");
        rd(3'd4, 8'h85, 8'hFF, 0, "fix_claim1");
        rd(3'd4, 8'h00, 8'hFF, 0, "fix_claim2");
        idl(8'hFF, 1, "fix_idle");
        // Round-robin with level sources 1 and 6, pointer from reset
        rs(8'hFF, "rr_rst");
        wr(3'd3, 8'h03, 8'hFF); wr(3'd1, 8'hFF, 8'hFF);
        idl(8'hBD, -1, "rr_w0"); idl(8'hBD, -1, "rr_w1"); idl(8'hBD, -1, "rr_w2");
        rd(3'd4, 8'h81, 8'hBD, 0, "rr_claim0");
        rd(3'd4, 8'h86, 8'hBD, 0, "rr_claim1");
        rd(3'd4, 8'h81, 8'hBD, 0, "rr_claim2");
        rd(3'd4, 8'h86, 8'hBD, 0, "rr_claim3");
        // Asynchronous reset while the line is asserted
        rs(8'hBD, "mid_rst");
        idl(8'hBD, 1, "post_rst0"); idl(8'hBD, 1, "post_rst1"); idl(8'hBD, 1, "post_rst2");
        pk(3'd1, 8'h00, 8'hBD, 1, "post_rst_en");
        // Set/clear collision on source 4
        wr(3'd2, 8'h10, 8'hFF); wr(3'd1, 8'h10, 8'hFF); wr(3'd3, 8'h01, 8'hFF);
        idl(8'hEF, -1, "col_a0"); idl(8'hEF, -1, "col_a1");
        for (int i = 0; i < 4; i++) idl(8'hFF, -1, "col_gap");
        pk(3'd0, 8'h10, 8'hFF, 0, "col_pre");
        idl(8'hEF, -1, "col_b0"); idl(8'hEF, -1, "col_b1");
        wr(3'd0, 8'h10, 8'hEF);
        pk(3'd0, 8'h10, 8'hEF, -1, "col_set_wins");
        wr(3'd0, 8'h10, 8'hEF);
        pk(3'd0, 8'h00, 8'hEF, -1, "col_w1c");

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].cs, vecs[i].rwb, vecs[i].addr, vecs[i].data, vecs[i].irqb,
                  gd, gi, ed, ei);
            if (vecs[i].exp_data >= 0) check({vnames[i], "_data"}, gd, 8'(vecs[i].exp_data));
            if (vecs[i].exp_irq >= 0)  check({vnames[i], "_irqb"}, {7'b0, gi}, 8'(vecs[i].exp_irq));
        end

        // Random traffic against the model
        q = 8'hFF;
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 8'h00, q, gd, gi, ed, ei);
        for (int n = 0; n < 3000; n++) begin
            logic       cs, rwb, rst;
            logic [2:0] a;
            logic [7:0] d;
            int         op = $urandom_range(0, 19);
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) q[b] = ~q[b];
            rst = ($urandom_range(0, 599) == 0);
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            cs  = (op >= 8);
            rwb = (op < 14);
            if (op >= 11 && op < 14) a = 3'd4;
            if (op >= 14 && op < 16) a = 3'd0;
            if (op == 16) begin a = 3'd3; d = {6'b0, d[1:0]}; end
            cycle(rst, cs, rwb, a, d, q, gd, gi, ed, ei);
            check($sformatf("rnd%0d_data", n), gd, ed);
            check($sformatf("rnd%0d_irqb", n), {7'b0, gi}, {7'b0, ei});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
